// File: rtl/rv_fetch_pkg.sv
// Shared fetch-side types and helpers for the instruction aligner.
// The compressed-instruction path is enabled by defining ALIGNER_RVC_EN.
package rv_fetch_pkg;

   typedef logic [15:0] halfword_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      H1    = 2'd1,
      H2    = 2'd2,
      H3    = 2'd3
   } aligner_state_e;

   // Low opcode bits that mark a full 32-bit instruction.
   localparam logic [1:0] OPC_LEN32 = 2'b11;

   function automatic logic is_compressed(input halfword_t hw);
      return hw[1:0] != OPC_LEN32;
   endfunction

endpackage

// File: rtl/halfword_fifo.sv
// Three-entry halfword queue: pushes one or two halfwords, pops one or two.
// A same-cycle pop is applied first, and the push lands behind what remains.
module halfword_fifo
   import rv_fetch_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           push,
   input  logic           push_lo,
   input  logic [31:0]    push_data,
   input  logic           pop,
   input  logic           pop_two,
   output aligner_state_e count,
   output halfword_t      head0,
   output halfword_t      head1
);

   halfword_t  q_q [3];
   halfword_t  q_d [3];
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic [1:0] keep;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      q_d   = q_q;
      keep  = cnt_q;
      cnt_d = cnt_q;

      if (pop) begin
         if (pop_two) begin
            q_d[0] = q_q[2];
            q_d[1] = q_q[2];
            keep   = cnt_q - 2'd2;
         end else begin
            q_d[0] = q_q[1];
            q_d[1] = q_q[2];
            keep   = cnt_q - 2'd1;
         end
      end
      cnt_d = keep;

      if (push) begin
         if (push_lo) begin
            case (keep)
               2'd0: begin
                  q_d[0] = push_data[15:0];
                  q_d[1] = push_data[31:16];
               end
               2'd1: begin
                  q_d[1] = push_data[15:0];
                  q_d[2] = push_data[31:16];
               end
               default: q_d[2] = push_data[15:0];
            endcase
            cnt_d = keep + 2'd2;
         end else begin
            case (keep)
               2'd0:    q_d[0] = push_data[31:16];
               2'd1:    q_d[1] = push_data[31:16];
               2'd2:    q_d[2] = push_data[31:16];
               default: ;
            endcase
            cnt_d = keep + 2'd1;
         end
      end

      if (clear) cnt_d = 2'd0;
   end

   // NOTE: the storage is reset too, so the idle outputs read as zero rather than X.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 2'd0;
         for (int i = 0; i < 3; i++) q_q[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   assign count = aligner_state_e'(cnt_q);
   assign head0 = q_q[0];
   assign head1 = q_q[1];

endmodule

// File: rtl/instr_aligner.sv
// Fetch realigner: turns word-aligned fetch words into 16/32-bit instructions with PCs.
// Define ALIGNER_RVC_EN to enable compressed instructions; otherwise each word is one instruction.
module instr_aligner
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_is_c,
   output logic [15:0] out_instr_16
);

`ifdef ALIGNER_RVC_EN
   localparam bit RVC_EN = 1'b1;
`else
   localparam bit RVC_EN = 1'b0;
`endif

   aligner_state_e count;
   halfword_t      hq0;
   halfword_t      hq1;
   logic [31:0]    pc_q;
   logic [31:0]    exp_addr_q;
   logic           skip_lo_q;
   logic           head_c;
   logic           push;
   logic           pop;

   // Without RVC the head is never compressed, so only whole words move through.
   assign head_c = RVC_EN && (count != EMPTY) && is_compressed(hq0);

   assign in_ready     = (count <= H1) || flush;
   assign out_valid    = !flush && (head_c || (count >= H2));
   assign out_is_c     = head_c;
   assign out_instr    = head_c ? {16'h0000, hq0} : {hq1, hq0};
   assign out_instr_16 = out_instr[15:0];
   assign out_pc       = pc_q;

   // Words off the expected address are still consumed, just not stored.
   assign push = in_valid && in_ready && !flush && (in_addr == exp_addr_q);
   assign pop  = out_valid && out_ready;

   halfword_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (push),
      .push_lo   (!skip_lo_q),
      .push_data (in_data),
      .pop       (pop),
      .pop_two   (!head_c),
      .count     (count),
      .head0     (hq0),
      .head1     (hq1)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         exp_addr_q <= {RESET_PC[31:2], 2'b00};
         skip_lo_q  <= RVC_EN && RESET_PC[1];
      end else if (flush) begin
         pc_q       <= RVC_EN ? flush_pc : {flush_pc[31:2], 2'b00};
         exp_addr_q <= {flush_pc[31:2], 2'b00};
         skip_lo_q  <= RVC_EN && flush_pc[1];
      end else begin
         if (pop) pc_q <= pc_q + (head_c ? 32'd2 : 32'd4);
         if (push) begin
            exp_addr_q <= exp_addr_q + 32'd4;
            skip_lo_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: a halfword-queue reference model predicts each instruction.
// Follows the DUT build: define ALIGNER_RVC_EN for both or for neither.
module tb_instr_aligner;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef ALIGNER_RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] flush_pc;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_is_c;
   logic [15:0] out_instr_16;

   instr_aligner #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .out_is_c     (out_is_c),
      .out_instr_16 (out_instr_16)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        is_c;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_exp;
   logic        m_skip;
   int          checks   = 0;
   int          failures = 0;
   int          rdy_mode = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic void model_redirect(input logic [31:0] pc);
      expq.delete();
      mq.delete();
      m_pc   = RVC ? pc : {pc[31:2], 2'b00};
      m_exp  = {pc[31:2], 2'b00};
      m_skip = RVC && pc[1];
   endfunction

   // Accepted word -> append halfwords, then peel off every complete instruction.
   function automatic void model_word(input logic [31:0] a, input logic [31:0] d);
      logic [15:0] dummy;
      if (a != m_exp) return;
      m_exp += 32'd4;
      if (!RVC) begin
         expq.push_back('{m_pc, d, 1'b0});
         m_pc += 32'd4;
         return;
      end
      if (!m_skip) mq.push_back(d[15:0]);
      mq.push_back(d[31:16]);
      m_skip = 1'b0;
      while (mq.size() > 0) begin
         if (mq[0][1:0] != 2'b11) begin
            expq.push_back('{m_pc, {16'h0000, mq[0]}, 1'b1});
            dummy = mq.pop_front();
            m_pc += 32'd2;
         end else if (mq.size() >= 2) begin
            expq.push_back('{m_pc, {mq[1], mq[0]}, 1'b0});
            dummy = mq.pop_front();
            dummy = mq.pop_front();
            m_pc += 32'd4;
         end else begin
            break;
         end
      end
   endfunction

   // Monitor: sees what the coming clock edge will do and checks every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (flush) begin
            check("flush_blocks_out_valid", {31'b0, out_valid}, 32'd0);
            model_redirect(flush_pc);
         end else begin
            if (out_valid && out_ready) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output pc=%h instr=%h (none expected)", out_pc, out_instr);
               end else begin
                  e = expq.pop_front();
                  check("out_pc", out_pc, e.pc);
                  check("out_instr", out_instr, e.instr);
                  check("out_is_c", {31'b0, out_is_c}, {31'b0, e.is_c});
                  check("out_instr_16", {16'h0, out_instr_16}, {16'h0, e.instr[15:0]});
               end
            end
            if (in_valid && in_ready) model_word(in_addr, in_data);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'($urandom_range(0, 1));
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   task automatic send(input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("send_accepted", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush    = 1'b1;
      flush_pc = pc;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 1;
      while (expq.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check("drain_complete", expq.size(), 32'd0);
      @(posedge clk);
      #1;
      check("idle_after_drain", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] p;
      int          nw;
      reset    = 1'b1;
      flush    = 1'b0;
      flush_pc = '0;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      out_ready = 1'b0;
      model_redirect(RESET_PC);
      #12;
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_out_pc", out_pc, RESET_PC);
      check("reset_out_instr", out_instr, 32'd0);
      check("reset_out_is_c", {31'b0, out_is_c}, 32'd0);
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Two compressed instructions in one word.
      send(32'h0, 32'h0001_4501);
      drain();

      // 32-bit instruction straddling two words.
      do_flush(32'h0);
      send(32'h0, 32'h0513_4501);
      repeat (4) @(posedge clk);
      #1;
      check("straddle_waits", {31'b0, out_valid}, 32'd0);
      send(32'h4, 32'h0001_0000);
      drain();

      // Redirect into the upper half of a word.
      do_flush(32'h102);
      send(32'h100, 32'h1234_ABCD);
      drain();

      // Stale word after a redirect is consumed and dropped.
      do_flush(32'h200);
      send(32'h104, 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      #1;
      check("stale_no_output", {31'b0, out_valid}, 32'd0);
      send(32'h200, 32'h0000_4501);
      drain();

      // Word presented in the flush cycle is dropped.
      in_valid = 1'b1;
      in_addr  = 32'h300;
      in_data  = 32'h0033_0093;
      do_flush(32'h300);
      in_valid = 1'b0;
      send(32'h300, 32'h0000_0000);
      drain();

      // Backpressure with 32-bit words: upstream must hold its word.
      do_flush(32'h0);
      rdy_mode = 2;
      send(32'h0, $urandom | 32'h3);
      repeat (2) @(posedge clk);
      #1;
      check("full_in_ready_low", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_addr  = 32'h4;
      in_data  = $urandom | 32'h3;
      repeat (3) @(posedge clk);
      #1;
      check("held_in_ready_low", {31'b0, in_ready}, 32'd0);
      rdy_mode = 1;
      send(32'h4, in_data);
      send(32'h8, 32'hFFFF_FFFF);
      drain();

      // PC and address wrap-around.
      do_flush(32'hFFFF_FFFA);
      rdy_mode = 0;
      send(32'hFFFF_FFF8, $urandom);
      send(32'hFFFF_FFFC, $urandom);
      send(32'h0000_0000, $urandom);
      drain();

      // Randomized streams with redirects, stale words and random backpressure.
      for (int it = 0; it < 20; it++) begin
         p = $urandom & 32'hFFFF_FFFE;
         do_flush(p);
         rdy_mode = 0;
         a  = {p[31:2], 2'b00};
         nw = $urandom_range(3, 10);
         for (int k = 0; k < nw; k++) begin
            if ($urandom_range(0, 5) == 0) send(a ^ 32'h40, $urandom);
            send(a, $urandom);
            a += 32'd4;
         end
         drain();
      end

      // Asynchronous reset in the middle of a straddled instruction.
      do_flush(32'h0);
      rdy_mode = 1;
      send(32'h0, 32'h0513_4501);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      model_redirect(RESET_PC);
      #1;
      check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
      check("midreset_out_pc", out_pc, RESET_PC);
      check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(32'h0, 32'h0001_4501);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
